// File: rtl/spi_slave_counter_bank.sv
// SPI slave fronting a bank of pulse counters: a command byte selects a channel,
// the slave returns a status byte of overflow flags and then a snapshot of that counter.
module spi_slave_counter_bank #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int COUNTER_WIDTH = 16,
    parameter int CPOL          = 0,
    parameter int CPHA          = 0,
    parameter int SATURATE      = 0
) (
    input  logic                                    SPI_CNT_CLOCK_50,
    input  logic                                    SPI_CNT_RESET_InLow,
    input  logic                                    SPI_CNT_SS_InLow,
    input  logic                                    SPI_CNT_SCK_In,
    input  logic                                    SPI_CNT_MOSI_In,
    input  logic [NUM_CHANNELS-1:0]                 SPI_CNT_COUNT_InHigh,
    output logic                                    SPI_CNT_MISO_Out,
    output logic [DATAWIDTH_BUS-1:0]                SPI_CNT_cmd_Out,
    output logic                                    SPI_CNT_newCmd_Out,
    output logic [NUM_CHANNELS*COUNTER_WIDTH-1:0]   SPI_CNT_counters_Out,
    output logic [NUM_CHANNELS-1:0]                 SPI_CNT_overflow_Out,
    output logic [1:0]                              SPI_CNT_state_Out
);

    localparam int   W      = DATAWIDTH_BUS;
    localparam int   CW     = COUNTER_WIDTH;
    localparam int   N      = NUM_CHANNELS;
    localparam int   CH_W   = W - 1;
    localparam int   BIT_W  = $clog2(CW) + 1;
    localparam logic CPOL_B = (CPOL != 0);

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_IGNORE} state_t;

    logic          ss_s1_q, ss_s2_q, ss_dly_q;
    logic          sck_s1_q, sck_s2_q, sck_dly_q;
    logic          mosi_s1_q, mosi_s2_q;
    logic [N-1:0]  cnt_in_s1_q, cnt_in_s2_q, cnt_in_dly_q;

    logic          ss_fall, ss_rise, sck_lead, sck_trail, sample_edge, shift_edge;
    logic [N-1:0]  cnt_rise;

    state_t        state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CH_W-1:0]  rx_q, rx_d;
    logic [CW-1:0]    tx_q, tx_d;
    logic          miso_q, miso_d;
    logic [W-1:0]  cmd_q, cmd_d;
    logic          newcmd_q, newcmd_d;

    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];
    logic [N-1:0]  ovf_q, ovf_d;

    logic [W-1:0]  cmd_byte;
    logic [N-1:0]  chan_hit;
    logic [N-1:0]  clr_vec;
    logic [CW-1:0] snap;
    logic [CW-1:0] status_full;

    // Two-flop synchronizers plus one delay flop for edge detection.
    always_ff @(posedge SPI_CNT_CLOCK_50) begin
        if (!SPI_CNT_RESET_InLow) begin
            ss_s1_q      <= 1'b1;
            ss_s2_q      <= 1'b1;
            ss_dly_q     <= 1'b1;
            sck_s1_q     <= CPOL_B;
            sck_s2_q     <= CPOL_B;
            sck_dly_q    <= CPOL_B;
            mosi_s1_q    <= 1'b0;
            mosi_s2_q    <= 1'b0;
            cnt_in_s1_q  <= '0;
            cnt_in_s2_q  <= '0;
            cnt_in_dly_q <= '0;
        end else begin
            ss_s1_q      <= SPI_CNT_SS_InLow;
            ss_s2_q      <= ss_s1_q;
            ss_dly_q     <= ss_s2_q;
            sck_s1_q     <= SPI_CNT_SCK_In;
            sck_s2_q     <= sck_s1_q;
            sck_dly_q    <= sck_s2_q;
            mosi_s1_q    <= SPI_CNT_MOSI_In;
            mosi_s2_q    <= mosi_s1_q;
            cnt_in_s1_q  <= SPI_CNT_COUNT_InHigh;
            cnt_in_s2_q  <= cnt_in_s1_q;
            cnt_in_dly_q <= cnt_in_s2_q;
        end
    end

    assign ss_fall     = ss_dly_q & ~ss_s2_q;
    assign ss_rise     = ~ss_dly_q & ss_s2_q;
    assign sck_lead    = (sck_dly_q == CPOL_B) && (sck_s2_q != CPOL_B);
    assign sck_trail   = (sck_dly_q != CPOL_B) && (sck_s2_q == CPOL_B);
    assign sample_edge = (CPHA != 0) ? sck_trail : sck_lead;
    assign shift_edge  = (CPHA != 0) ? sck_lead  : sck_trail;
    assign cnt_rise    = cnt_in_s2_q & ~cnt_in_dly_q;

    // Status byte sits in the top of the transmit register so both phases shift from the MSB.
    assign status_full = COUNTER_WIDTH'(ovf_q) << (CW - W);

    always_comb begin
        cmd_byte = {rx_q, mosi_s2_q};
        chan_hit = '0;
        snap     = '0;
        for (int i = 0; i < N; i++) begin
            chan_hit[i] = (cmd_byte[CH_W-1:0] == CH_W'(i));
            if (chan_hit[i]) snap = cnt_q[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        cmd_d     = cmd_q;
        newcmd_d  = 1'b0;
        clr_vec   = '0;
        if (ss_rise) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b0;
                    if (ss_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = '0;
                        rx_d      = '0;
                        if (CPHA == 0) begin
                            miso_d = status_full[CW-1];
                            tx_d   = status_full << 1;
                        end else begin
                            tx_d   = status_full;
                        end
                    end
                end
                ST_CMD: begin
                    if (sample_edge) begin
                        rx_d      = cmd_byte[CH_W-1:0];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_W'(W - 1)) begin
                            cmd_d     = cmd_byte;
                            newcmd_d  = 1'b1;
                            bit_cnt_d = '0;
                            if (|chan_hit) begin
                                state_d = ST_DATA;
                                tx_d    = snap;
                                if (cmd_byte[W-1]) clr_vec = chan_hit;
                            end else begin
                                state_d = ST_IGNORE;
                                miso_d  = 1'b0;
                            end
                        end
                    end else if (shift_edge) begin
                        miso_d = tx_q[CW-1];
                        tx_d   = tx_q << 1;
                    end
                end
                ST_DATA: begin
                    if (sample_edge) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_W'(CW - 1)) begin
                            state_d = ST_IGNORE;
                            miso_d  = 1'b0;
                        end
                    end else if (shift_edge) begin
                        miso_d = tx_q[CW-1];
                        tx_d   = tx_q << 1;
                    end
                end
                default: miso_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge SPI_CNT_CLOCK_50) begin
        if (!SPI_CNT_RESET_InLow) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            cmd_q     <= '0;
            newcmd_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            cmd_q     <= cmd_d;
            newcmd_q  <= newcmd_d;
        end
    end

    // A clear and a count edge in the same cycle leave the counter at 1 so no event is lost.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (clr_vec[i]) begin
                cnt_d[i] = cnt_rise[i] ? CW'(1) : '0;
                ovf_d[i] = 1'b0;
            end else if (cnt_rise[i]) begin
                if (&cnt_q[i]) begin
                    ovf_d[i] = 1'b1;
                    cnt_d[i] = (SATURATE != 0) ? cnt_q[i] : '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge SPI_CNT_CLOCK_50) begin
        if (!SPI_CNT_RESET_InLow) begin
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
            ovf_q <= ovf_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_cnt_out
        assign SPI_CNT_counters_Out[g*CW +: CW] = cnt_q[g];
    end

    assign SPI_CNT_MISO_Out     = miso_q;
    assign SPI_CNT_cmd_Out      = cmd_q;
    assign SPI_CNT_newCmd_Out   = newcmd_q;
    assign SPI_CNT_overflow_Out = ovf_q;
    assign SPI_CNT_state_Out    = state_q;

endmodule

// File: tb/tb_spi_slave_counter_bank.sv
// Bench for spi_slave_counter_bank: four 16-bit instances (one per SPI mode) and two
// 8-bit mode-0 instances (wrap and saturate) with a bit-banged SPI master.
module tb_spi_slave_counter_bank;

    localparam int HALF = 4;

    logic        clk;
    logic        rst_n;
    logic [5:0]  ss, sck, mosi;
    logic [3:0]  count_a, count_b;
    wire  [5:0]  miso, newcmd;
    wire  [7:0]  cmd_o [6];
    wire  [3:0]  ovf [6];
    wire  [1:0]  st [6];
    wire  [63:0] cnt16 [4];
    wire  [31:0] cnt8 [2];

    int          checks = 0;
    int          failures = 0;
    int          ncmd_cnt [6];
    logic [63:0] cnt_at_cmd0;
    logic [23:0] rx;
    int          n0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_slave_counter_bank #(.CPOL(g / 2), .CPHA(g % 2)) u_dut (
            .SPI_CNT_CLOCK_50(clk), .SPI_CNT_RESET_InLow(rst_n),
            .SPI_CNT_SS_InLow(ss[g]), .SPI_CNT_SCK_In(sck[g]), .SPI_CNT_MOSI_In(mosi[g]),
            .SPI_CNT_COUNT_InHigh(count_a), .SPI_CNT_MISO_Out(miso[g]),
            .SPI_CNT_cmd_Out(cmd_o[g]), .SPI_CNT_newCmd_Out(newcmd[g]),
            .SPI_CNT_counters_Out(cnt16[g]), .SPI_CNT_overflow_Out(ovf[g]),
            .SPI_CNT_state_Out(st[g])
        );
    end

    for (genvar g = 0; g < 2; g++) begin : g_w8
        spi_slave_counter_bank #(.COUNTER_WIDTH(8), .SATURATE(g)) u_dut (
            .SPI_CNT_CLOCK_50(clk), .SPI_CNT_RESET_InLow(rst_n),
            .SPI_CNT_SS_InLow(ss[4+g]), .SPI_CNT_SCK_In(sck[4+g]), .SPI_CNT_MOSI_In(mosi[4+g]),
            .SPI_CNT_COUNT_InHigh(count_b), .SPI_CNT_MISO_Out(miso[4+g]),
            .SPI_CNT_cmd_Out(cmd_o[4+g]), .SPI_CNT_newCmd_Out(newcmd[4+g]),
            .SPI_CNT_counters_Out(cnt8[g]), .SPI_CNT_overflow_Out(ovf[4+g]),
            .SPI_CNT_state_Out(st[4+g])
        );
    end

    always @(negedge clk) begin
        for (int k = 0; k < 6; k++) if (newcmd[k]) ncmd_cnt[k]++;
        if (newcmd[0]) cnt_at_cmd0 = cnt16[0];
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_a(input int ch, input int n);
        repeat (n) begin
            count_a[ch] = 1'b1; wait_clk(2);
            count_a[ch] = 1'b0; wait_clk(2);
        end
        wait_clk(4);
    endtask

    task automatic pulse_b(input int ch, input int n);
        repeat (n) begin
            count_b[ch] = 1'b1; wait_clk(2);
            count_b[ch] = 1'b0; wait_clk(2);
        end
        wait_clk(4);
    endtask

    // Master for bus m: shifts nbits of tx MSB first, captures MISO on the mode's sample edge.
    // pulse_ch >= 0 raises that count_a input together with the edge sampling the last command bit.
    task automatic spi_frame(input int m, input logic [23:0] tx, input int nbits,
                             input int pulse_ch, output logic [23:0] rx_o);
        logic cpol, cpha;
        cpol = (m < 4) ? m[1] : 1'b0;
        cpha = (m < 4) ? m[0] : 1'b0;
        rx_o = '0;
        sck[m]  = cpol;
        mosi[m] = cpha ? 1'b0 : tx[nbits-1];
        ss[m]   = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            if (!cpha) begin
                wait_clk(HALF);
                rx_o[nbits-1-b] = miso[m];
                sck[m] = ~cpol;
                if (pulse_ch >= 0 && b == 7) count_a[pulse_ch] = 1'b1;
                wait_clk(HALF);
                sck[m] = cpol;
                if (pulse_ch >= 0) count_a[pulse_ch] = 1'b0;
                if (b < nbits - 1) mosi[m] = tx[nbits-2-b];
            end else begin
                wait_clk(HALF);
                sck[m]  = ~cpol;
                mosi[m] = tx[nbits-1-b];
                wait_clk(HALF);
                rx_o[nbits-1-b] = miso[m];
                sck[m] = cpol;
            end
        end
        wait_clk(HALF);
        ss[m] = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(2);
        for (int m = 0; m < 6; m++) begin
            checks++;
            if ({miso[m], newcmd[m], cmd_o[m], ovf[m], st[m]} !== 16'h0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d: got %h expected 0", m,
                         {miso[m], newcmd[m], cmd_o[m], ovf[m], st[m]});
            end
        end
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (cnt16[m] !== 64'h0) begin
                failures++;
                $display("FAIL reset_counters dut%0d: got %h expected 0", m, cnt16[m]);
            end
        end
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (cnt8[m] !== 32'h0) begin
                failures++;
                $display("FAIL reset_counters8 dut%0d: got %h expected 0", m + 4, cnt8[m]);
            end
        end
    endtask

    task automatic test_count_read;
        pulse_a(2, 5);
        checks++;
        if (cnt16[0][47:32] !== 16'h0005) begin
            failures++;
            $display("FAIL count_ch2: got %h expected 0005", cnt16[0][47:32]);
        end
        n0 = ncmd_cnt[0];
        spi_frame(0, 24'h020000, 24, -1, rx);
        checks++;
        if (rx !== 24'h000005) begin
            failures++;
            $display("FAIL read_ch2: got %h expected 000005", rx);
        end
        checks++;
        if (ncmd_cnt[0] !== n0 + 1) begin
            failures++;
            $display("FAIL newcmd_once: got %0d expected %0d", ncmd_cnt[0], n0 + 1);
        end
        checks++;
        if (cmd_o[0] !== 8'h02 || cnt16[0][47:32] !== 16'h0005) begin
            failures++;
            $display("FAIL cmd_and_keep: got cmd %h cnt %h expected 02 0005",
                     cmd_o[0], cnt16[0][47:32]);
        end
    endtask

    task automatic test_clear_after_read;
        pulse_a(1, 7);
        spi_frame(0, 24'h810000, 24, -1, rx);
        checks++;
        if (rx !== 24'h000007) begin
            failures++;
            $display("FAIL read_clear_ch1: got %h expected 000007", rx);
        end
        checks++;
        if (cnt_at_cmd0[31:16] !== 16'h0 || cnt16[0][31:16] !== 16'h0) begin
            failures++;
            $display("FAIL cleared_ch1: got %h/%h expected 0000", cnt_at_cmd0[31:16], cnt16[0][31:16]);
        end
        checks++;
        if (cnt16[1][31:16] !== 16'h0007) begin
            failures++;
            $display("FAIL other_dut_ch1: got %h expected 0007", cnt16[1][31:16]);
        end
    endtask

    task automatic test_modes;
        pulse_a(3, 16'h1234);
        for (int m = 0; m < 4; m++) begin
            spi_frame(m, 24'h030000, 24, -1, rx);
            checks++;
            if (rx !== 24'h001234 || cmd_o[m] !== 8'h03) begin
                failures++;
                $display("FAIL mode%0d_read_ch3: got %h cmd %h expected 001234 03", m, rx, cmd_o[m]);
            end
        end
    endtask

    task automatic test_overflow;
        pulse_b(0, 255);
        checks++;
        if (cnt8[0][7:0] !== 8'hFF || ovf[4] !== 4'h0 || cnt8[1][7:0] !== 8'hFF) begin
            failures++;
            $display("FAIL preload_ff: got %h ovf %h sat %h expected ff 0 ff",
                     cnt8[0][7:0], ovf[4], cnt8[1][7:0]);
        end
        pulse_b(0, 1);
        checks++;
        if (cnt8[0][7:0] !== 8'h00 || ovf[4] !== 4'h1) begin
            failures++;
            $display("FAIL wrap: got %h ovf %h expected 00 1", cnt8[0][7:0], ovf[4]);
        end
        checks++;
        if (cnt8[1][7:0] !== 8'hFF || ovf[5] !== 4'h1) begin
            failures++;
            $display("FAIL saturate: got %h ovf %h expected ff 1", cnt8[1][7:0], ovf[5]);
        end
        spi_frame(4, 24'h008000, 16, -1, rx);
        checks++;
        if (rx[15:0] !== 16'h0100 || ovf[4] !== 4'h0) begin
            failures++;
            $display("FAIL wrap_status_clear: got %h ovf %h expected 0100 0", rx[15:0], ovf[4]);
        end
        spi_frame(5, 24'h000000, 16, -1, rx);
        checks++;
        if (rx[15:0] !== 16'h01FF || ovf[5] !== 4'h1 || cnt8[1][7:0] !== 8'hFF) begin
            failures++;
            $display("FAIL sat_read_noclear: got %h ovf %h cnt %h expected 01ff 1 ff",
                     rx[15:0], ovf[5], cnt8[1][7:0]);
        end
        spi_frame(5, 24'h008000, 16, -1, rx);
        checks++;
        if (rx[15:0] !== 16'h01FF || ovf[5] !== 4'h0 || cnt8[1][7:0] !== 8'h00) begin
            failures++;
            $display("FAIL sat_read_clear: got %h ovf %h cnt %h expected 01ff 0 00",
                     rx[15:0], ovf[5], cnt8[1][7:0]);
        end
    endtask

    task automatic test_partial;
        n0 = ncmd_cnt[0];
        spi_frame(0, 24'h00000A, 4, -1, rx);
        checks++;
        if (ncmd_cnt[0] !== n0 || cmd_o[0] !== 8'h03 || st[0] !== 2'd0) begin
            failures++;
            $display("FAIL partial_abort: got ncmd %0d cmd %h st %0d expected %0d 03 0",
                     ncmd_cnt[0], cmd_o[0], st[0], n0);
        end
        spi_frame(0, 24'h020000, 24, -1, rx);
        checks++;
        if (rx !== 24'h000005 || ncmd_cnt[0] !== n0 + 1) begin
            failures++;
            $display("FAIL after_partial: got %h ncmd %0d expected 000005 %0d", rx, ncmd_cnt[0], n0 + 1);
        end
    endtask

    task automatic test_ignore;
        spi_frame(0, 24'h090000, 24, -1, rx);
        checks++;
        if (rx !== 24'h000000 || cmd_o[0] !== 8'h09) begin
            failures++;
            $display("FAIL ignore_read: got %h cmd %h expected 000000 09", rx, cmd_o[0]);
        end
        checks++;
        if (cnt16[0] !== 64'h1234_0005_0000_0000 || st[0] !== 2'd0) begin
            failures++;
            $display("FAIL ignore_counters: got %h st %0d expected 1234000500000000 0", cnt16[0], st[0]);
        end
    endtask

    task automatic test_collision;
        pulse_a(0, 3);
        spi_frame(0, 24'h800000, 24, 0, rx);
        checks++;
        if (rx !== 24'h000003 || cnt16[0][15:0] !== 16'h0001) begin
            failures++;
            $display("FAIL clear_collision: got %h cnt %h expected 000003 0001", rx, cnt16[0][15:0]);
        end
        spi_frame(0, 24'h000000, 24, 0, rx);
        checks++;
        if (rx !== 24'h000001 || cnt16[0][15:0] !== 16'h0002) begin
            failures++;
            $display("FAIL snap_collision: got %h cnt %h expected 000001 0002", rx, cnt16[0][15:0]);
        end
    endtask

    task automatic test_back_to_back;
        spi_frame(0, 24'h020000, 24, -1, rx);
        spi_frame(0, 24'h030000, 24, -1, rx);
        checks++;
        if (rx !== 24'h001234 || cmd_o[0] !== 8'h03) begin
            failures++;
            $display("FAIL back_to_back: got %h cmd %h expected 001234 03", rx, cmd_o[0]);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        ss      = '1;
        sck     = 6'b001100;
        mosi    = '0;
        count_a = '0;
        count_b = '0;
        test_reset;
        test_count_read;
        test_clear_after_read;
        test_modes;
        test_overflow;
        test_partial;
        test_ignore;
        test_collision;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
